// File: rtl/stm32_bus_master.sv
// Initiator side of the STM32 <-> DDC 4-bit nibble bus: one request at a time,
// drives sync/nibbles for writes and assembles responder nibbles for reads.
module stm32_bus_master #(
  parameter int READ_LATENCY = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic        req_tx,
  input  logic        req_preamp,
  input  logic [21:0] req_freq,
  input  logic [15:0] req_i,
  input  logic [15:0] req_q,
  output logic        sync_out,
  output logic [3:0]  data_out,
  input  logic [3:0]  bus_in,
  output logic [15:0] rx_i,
  output logic [15:0] rx_q,
  output logic        rx_valid,
  output logic        adc_otr,
  output logic        status_valid,
  output logic        done,
  output logic        done_err
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_WR, S_RD, S_DONE, S_GAP} state_t;

  localparam logic [2:0] CMD_SET    = 3'd1;
  localparam logic [2:0] CMD_STATUS = 3'd2;
  localparam logic [2:0] CMD_TX     = 3'd3;
  localparam logic [2:0] CMD_RX     = 3'd4;
  localparam logic [3:0] RD_FIRST   = 4'(READ_LATENCY - 1);
  localparam logic [3:0] RX_LAST    = 4'(READ_LATENCY + 6);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [2:0]  cmd_q, cmd_nxt;
  logic [31:0] pay, pay_nxt;
  logic [31:0] samp;
  logic [3:0]  wr_last;
  logic        sync_nxt, rx_valid_nxt, adc_nxt, stat_v_nxt, done_nxt, err_nxt;
  logic [3:0]  data_nxt;
  logic [15:0] rx_i_nxt, rx_q_nxt;

  assign req_ready = (state == S_IDLE);

  // pay is the outgoing nibble shifter for writes and the incoming one for reads
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 4'd1;
    cmd_nxt      = cmd_q;
    pay_nxt      = pay;
    sync_nxt     = 1'b0;
    data_nxt     = 4'h0;
    rx_i_nxt     = rx_i;
    rx_q_nxt     = rx_q;
    rx_valid_nxt = 1'b0;
    adc_nxt      = adc_otr;
    stat_v_nxt   = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    samp         = {pay[27:0], bus_in};
    wr_last      = (cmd_q == CMD_SET) ? 4'd6 : 4'd7;

    case (state)
      S_IDLE: begin
        cnt_nxt = 4'd0;
        if (req_valid) begin
          cmd_nxt = req_cmd;
          case (req_cmd)
            CMD_SET: pay_nxt = {req_tx, req_preamp, 4'b0000, req_freq, 4'b0000};
            CMD_TX:  pay_nxt = {req_q, req_i};
            default: pay_nxt = 32'h0;
          endcase
          if (req_cmd >= CMD_SET && req_cmd <= CMD_RX) begin
            state_nxt = S_SYNC;
            sync_nxt  = 1'b1;
            data_nxt  = {1'b0, req_cmd};
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
        end
      end
      S_SYNC: begin
        cnt_nxt = 4'd0;
        if (cmd_q == CMD_SET || cmd_q == CMD_TX) begin
          state_nxt = S_WR;
          data_nxt  = pay[31:28];
          pay_nxt   = pay << 4;
        end else begin
          state_nxt = S_RD;
        end
      end
      S_WR: begin
        if (cnt == wr_last) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          data_nxt = pay[31:28];
          pay_nxt  = pay << 4;
        end
      end
      S_RD: begin
        if (cnt >= RD_FIRST) pay_nxt = samp;
        if (cmd_q == CMD_STATUS && cnt == RD_FIRST) begin
          state_nxt  = S_DONE;
          adc_nxt    = bus_in[0];
          stat_v_nxt = 1'b1;
          done_nxt   = 1'b1;
        end else if (cmd_q == CMD_RX && cnt == RX_LAST) begin
          state_nxt    = S_DONE;
          rx_q_nxt     = samp[31:16];
          rx_i_nxt     = samp[15:0];
          rx_valid_nxt = 1'b1;
          done_nxt     = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_GAP;
        cnt_nxt   = 4'd0;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      cmd_q        <= 3'd0;
      pay          <= 32'h0;
      sync_out     <= 1'b0;
      data_out     <= 4'h0;
      rx_i         <= 16'h0;
      rx_q         <= 16'h0;
      rx_valid     <= 1'b0;
      adc_otr      <= 1'b0;
      status_valid <= 1'b0;
      done         <= 1'b0;
      done_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cmd_q        <= cmd_nxt;
      pay          <= pay_nxt;
      sync_out     <= sync_nxt;
      data_out     <= data_nxt;
      rx_i         <= rx_i_nxt;
      rx_q         <= rx_q_nxt;
      rx_valid     <= rx_valid_nxt;
      adc_otr      <= adc_nxt;
      status_valid <= stat_v_nxt;
      done         <= done_nxt;
      done_err     <= err_nxt;
    end
  end

endmodule
